// File: rtl/adder_rr_scheduler_if.sv
// Request/response bundle between client engines and the shared-adder scheduler.
// The master side issues operand requests and consumes results; the slave side is the scheduler.
interface adder_rr_scheduler_if #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_sum;
  logic              resp_cout;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational adder between NREQ requesters,
// with a single-entry registered response (sum, carry-out, requester id) under valid/ready.
module adder_rr_scheduler #(
  parameter int W    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  adder_rr_scheduler_if.slave         bus,
  output logic [W-1:0]                add_a,
  output logic [W-1:0]                add_b,
  input  logic [W-1:0]                add_s,
  output logic [CNTW-1:0]             txn_count,
  output logic                        busy
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           grant_valid;
  logic           can_load;
  logic           fire;
  logic           consume;
  logic [IDW-1:0] ptr_next;
  logic           cout;

  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic [W-1:0]   resp_sum;
  logic           resp_cout;

  // Search from ptr upward with wrap; iterating from the far end lets the nearest hit win.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant       = ptr;
    idx         = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        grant_valid = 1'b1;
        grant       = IDW'(idx);
      end
    end
  end

  assign can_load = !resp_valid || bus.resp_ready;
  assign fire     = grant_valid && can_load && !rst;
  assign consume  = resp_valid && bus.resp_ready;

  assign bus.req_ready = fire ? (NREQ'(1) << grant) : '0;

  // With no grant, grant == ptr, so the adder still sees a defined operand pair.
  assign add_a = bus.req_a[int'(grant)*W +: W];
  assign add_b = bus.req_b[int'(grant)*W +: W];

  // Carry-out rebuilt from operand and sum MSBs since the shared adder exports only the sum.
  assign cout = (add_a[W-1] & add_b[W-1]) | ((add_a[W-1] ^ add_b[W-1]) & ~add_s[W-1]);

  assign ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      ptr        <= '0;
      txn_count  <= '0;
    end else begin
      if (fire) begin
        resp_sum   <= add_s;
        resp_cout  <= cout;
        resp_id    <= grant;
        resp_valid <= 1'b1;
        ptr        <= ptr_next;
      end else if (consume) begin
        resp_valid <= 1'b0;
      end
      if (consume && (txn_count != '1)) begin
        txn_count <= txn_count + CNTW'(1);
      end
    end
  end

  assign bus.resp_valid = resp_valid;
  assign bus.resp_id    = resp_id;
  assign bus.resp_sum   = resp_sum;
  assign bus.resp_cout  = resp_cout;

  assign busy = resp_valid || (|bus.req_valid);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: per-requester operand queues feed the DUT, a
// cycle model predicts grants and pushes expected results to a scoreboard popped on response.
module tb_adder_rr_scheduler;
  localparam int W     = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int CNTW  = 4;
  localparam int DEPTH = 64;
  localparam int CMAX  = (1 << CNTW) - 1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    add_a, add_b, add_s;
  logic [CNTW-1:0] txn_count;
  logic            busy;

  adder_rr_scheduler_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();

  adder_rr_scheduler #(.W(W), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .txn_count (txn_count),
    .busy      (busy)
  );

  // Shared combinational adder, no carry-in, sum only.
  assign add_s = add_a + add_b;

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [W-1:0] qa [NREQ][DEPTH];
  logic [W-1:0] qb [NREQ][DEPTH];
  int           qh [NREQ];
  int           qt [NREQ];

  exp_t exp_q[$];
  int   m_ptr;
  bit   m_rv;
  int   m_cnt;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(int i);
    return qh[i] != qt[i];
  endfunction

  function automatic bit pending_any();
    bit any = 1'b0;
    for (int i = 0; i < NREQ; i++) any |= pending(i);
    return any;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = pending(i);
      bus.req_a[i*W +: W]    = pending(i) ? qa[i][qh[i]] : '0;
      bus.req_b[i*W +: W]    = pending(i) ? qb[i][qh[i]] : '0;
    end
  endtask

  task automatic enq(int i, logic [W-1:0] a, logic [W-1:0] b);
    qa[i][qt[i]] = a;
    qb[i][qt[i]] = b;
    qt[i]++;
    drive();
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_rv  = 1'b0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // One clock: check outputs mid-cycle, advance the model, then drive after the edge.
  task automatic tick();
    int              g;
    int              sel;
    bit              gv;
    bit              can_load;
    logic [NREQ-1:0] exp_rr;
    logic [W:0]      full;
    @(negedge clk);
    check("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
    if (m_rv) begin
      check("resp_id",   32'(bus.resp_id),   32'(exp_q[0].id));
      check("resp_sum",  32'(bus.resp_sum),  32'(exp_q[0].sum));
      check("resp_cout", 32'(bus.resp_cout), 32'(exp_q[0].cout));
    end
    check("txn_count", 32'(txn_count), 32'(m_cnt));
    check("busy", 32'(busy), 32'(m_rv || pending_any()));

    gv = 1'b0;
    g  = m_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!gv && pending((m_ptr + k) % NREQ)) begin
        gv = 1'b1;
        g  = (m_ptr + k) % NREQ;
      end
    end
    can_load = !m_rv || bus.resp_ready;
    exp_rr   = (gv && can_load) ? (NREQ'(1) << g) : '0;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rr));
    sel = gv ? g : m_ptr;
    check("add_a", 32'(add_a), 32'(pending(sel) ? qa[sel][qh[sel]] : '0));
    check("add_b", 32'(add_b), 32'(pending(sel) ? qb[sel][qh[sel]] : '0));

    if (m_rv && bus.resp_ready) begin
      void'(exp_q.pop_front());
      if (m_cnt != CMAX) m_cnt++;
      m_rv = 1'b0;
    end
    if (gv && can_load) begin
      full = {1'b0, qa[g][qh[g]]} + {1'b0, qb[g][qh[g]]};
      exp_q.push_back('{id: IDW'(g), sum: full[W-1:0], cout: full[W]});
      qh[g]++;
      m_ptr = (g + 1) % NREQ;
      m_rv  = 1'b1;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((pending_any() || m_rv) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(pending_any() || m_rv), 32'(0));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(0));
    check({tag, "_resp_id"},    32'(bus.resp_id),    32'(0));
    check({tag, "_resp_sum"},   32'(bus.resp_sum),   32'(0));
    check({tag, "_resp_cout"},  32'(bus.resp_cout),  32'(0));
    check({tag, "_txn_count"},  32'(txn_count),      32'(0));
    check({tag, "_req_ready"},  32'(bus.req_ready),  32'(0));
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    model_reset();
    rst            = 1'b1;
    bus.resp_ready = 1'b1;
    drive();
    #1;
    check_reset_outputs("por");
    check("por_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // All four requesters continuously valid from ptr=0: ids 0,1,2,3,0,1,...
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NREQ; i++)
        enq(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    drain(40);

    // Single requester 0.
    enq(0, 8'h3C, 8'h41);
    drain(10);

    // Overflow cases on requester 2.
    enq(2, 8'hFF, 8'h01);
    enq(2, 8'h80, 8'h80);
    enq(2, 8'h7F, 8'h7F);
    drain(10);

    // Backpressure: five stalled cycles with requests pending, then resume.
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NREQ; i++)
        enq(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    tick();
    tick();
    bus.resp_ready = 1'b0;
    repeat (5) tick();
    bus.resp_ready = 1'b1;
    drain(40);

    // Starvation: move ptr to 2 via requester 1, then 1 and 3 alternate.
    enq(1, 8'h11, 8'h22);
    drain(10);
    for (int r = 0; r < 3; r++) begin
      enq(1, W'(8'h10 + r), 8'h01);
      enq(3, W'(8'h30 + r), 8'h02);
    end
    drain(20);

    // Reset mid-operation while a response is held and requests are pending.
    for (int r = 0; r < 3; r++)
      for (int i = 1; i < NREQ; i++)
        enq(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    tick();
    tick();
    check("pre_reset_resp_valid", 32'(bus.resp_valid), 32'(1));
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_req_ready", 32'(bus.req_ready), 32'(0));
    rst = 1'b0;
    model_reset();
    drain(40);

    // Counter saturation at 4 bits.
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < NREQ; i++)
        enq(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    drain(60);
    check("txn_count_saturated", 32'(txn_count), 32'(4'hF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one combinational W-bit prefix adder (external instance, no carry-in, sum-only output) between NREQ requesters.
- Round-robin arbitration picks one request per cycle and drives its operands onto the adder.
- The adder sum, the derived carry-out and the requester ID are registered into a single-entry response register with valid/ready flow control.
- Sits between client engines and the shared adder datapath. One result per cycle is sustained when resp_ready is held high.

Parameters:
- W, 8, operand/sum width; matches the shared adder.
- NREQ, 4, number of requesters, 2..16.
- IDW, 2, response ID width; IDW = clog2(NREQ).
- CNTW, 16, width of the saturating completed-transaction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*W  packed operand A; slice i = bits [i*W +: W]
- req_b  in  NREQ*W  packed operand B
- add_a  out  W  operand A to shared adder
- add_b  out  W  operand B to shared adder
- add_s  in  W  sum from shared adder (combinational from add_a/add_b)
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  consumer accepts response
- resp_id  out  IDW  index of the requester that produced the result
- resp_sum  out  W  registered sum
- resp_cout  out  1  registered carry-out of A+B
- txn_count  out  CNTW  completed responses, saturating
- busy  out  1  resp_valid OR any req_valid

Behaviour:
- Reset (async, rst=1): resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, txn_count=0, rr pointer=0. req_ready=0 while rst is asserted.
- can_load = !resp_valid || resp_ready (combinational).
- Arbitration (combinational):
  - Search req_valid starting at index ptr, ascending with wrap modulo NREQ.
  - The first valid index is grant g. If none is valid, there is no grant.
  - req_ready[g] = can_load; all other req_ready bits = 0.
- add_a/add_b = req_a/req_b slice g when a grant exists, otherwise slice ptr. The adder is always driven; no X values.
- Handshake fires for requester i when req_valid[i] && req_ready[i]. Requesters must hold valid and operands stable until accepted. A requester may not drop valid unaccepted (bench asserts this).
- On fire (posedge):
  - resp_sum <= add_s
  - resp_cout <= (a[W-1]&b[W-1]) | ((a[W-1]^b[W-1]) & ~add_s[W-1])
  - resp_id <= g
  - resp_valid <= 1
  - ptr <= (g+1) mod NREQ
- No fire but resp_valid && resp_ready: resp_valid <= 0. Data registers hold.
- Simultaneous consume and load in the same cycle: the new result replaces the old one, resp_valid stays 1. Zero bubble, throughput 1/cycle.
- resp_valid && !resp_ready: all req_ready=0, response registers and ptr hold, and resp_* are stable until accepted.
- Latency: request accepted in cycle n gives resp_valid in cycle n+1.
- ptr advances only on fire, never on idle cycles.
- Fairness: a continuously valid requester is granted within NREQ fires.
- txn_count increments on resp_valid && resp_ready and saturates at all-ones (no wrap).
- Sum arithmetic is modulo 2^W. resp_cout carries the 2^W bit (e.g. 0xFF+0x01 -> sum 0x00, cout 1).
- Reset asserted mid-operation: any pending response is discarded immediately. No response is emitted for a request accepted in the cycle reset rises.

Test Plan:
- Single requester 0, a=0x3C, b=0x41, resp_ready=1 -> next cycle resp_valid=1, resp_id=0, resp_sum=0x7D, resp_cout=0; txn_count=1.
- Overflow: requester 2, a=0xFF, b=0x01 -> resp_sum=0x00, resp_cout=1. Then a=0x80, b=0x80 -> sum 0x00, cout 1. Then a=0x7F, b=0x7F -> sum 0xFE, cout 0.
- All 4 requesters valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1 on consecutive cycles. Exactly one req_ready bit high per cycle.
- Backpressure: resp_ready=0 for 5 cycles with requests pending -> resp_* frozen, req_ready=0, ptr unchanged. On release, zero-bubble flow resumes.
- Starvation: req 1 and req 3 valid, ptr=2 -> grant 3 then 1, alternating. Requesters 0 and 2 idle do not stall.
- Reset pulse while resp_valid=1 and requests are pending -> outputs return to reset values asynchronously. After release the first grant goes to the lowest valid index from ptr=0. txn_count saturation is checked with CNTW=4: after 20 responses it reads 0xF.
